// File: rtl/free_list_bank.sv
`default_nettype none
// ============================================================================
// Module      : free_list_bank
// Description : One bank of the physical-register free list. A circular FIFO
//               of in-bank tags; the ROB commit path enqueues freed PRs and
//               rename dequeues new destination PRs.
// Revision    : 1.0 - initial release
// ============================================================================
module free_list_bank #(
    parameter int unsigned BANK_ID         = 0,
    parameter int unsigned LENGTH          = 32,
    parameter int unsigned LOG_LENGTH      = 5,
    parameter int unsigned INIT_FREE_BASE  = 8,
    parameter int unsigned LOWER_THRESHOLD = 8,
    parameter int unsigned UPPER_THRESHOLD = 24
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enq_valid,
    input  logic [LOG_LENGTH+1:0] enq_PR,
    output logic                  deq_valid,
    output logic [LOG_LENGTH+1:0] deq_PR,
    input  logic                  deq_ready,
    output logic [LOG_LENGTH:0]   count,
    output logic                  lower_flag,
    output logic                  upper_flag,
    output logic                  overflow_err,
    output logic                  bank_err
);

    localparam logic [1:0]            c_BANK      = 2'(BANK_ID);
    localparam logic [LOG_LENGTH:0]   c_FULL      = (LOG_LENGTH+1)'(LENGTH);
    localparam logic [LOG_LENGTH:0]   c_RST_COUNT = (LOG_LENGTH+1)'(LENGTH - INIT_FREE_BASE);
    localparam logic [LOG_LENGTH-1:0] c_RST_TAIL  = LOG_LENGTH'(LENGTH - INIT_FREE_BASE);
    localparam logic [LOG_LENGTH:0]   c_LOWER     = (LOG_LENGTH+1)'(LOWER_THRESHOLD);
    localparam logic [LOG_LENGTH:0]   c_UPPER     = (LOG_LENGTH+1)'(UPPER_THRESHOLD);

    logic [LOG_LENGTH-1:0] r_tags [LENGTH];
    logic [LOG_LENGTH-1:0] r_head;
    logic [LOG_LENGTH-1:0] r_tail;
    logic [LOG_LENGTH:0]   r_count;
    logic                  r_lower;
    logic                  r_upper;
    logic                  r_overflow;
    logic                  r_bank_err;

    logic                  w_full;
    logic                  w_deq_fire;
    logic                  w_enq_fire;
    logic                  w_overflow_evt;
    logic                  w_bank_evt;
    logic [LOG_LENGTH:0]   w_count_nxt;

    // Outputs depend only on registered head/count (and reset), never on enq_*.
    assign deq_valid    = (r_count != '0) & ~RST;
    assign deq_PR       = {r_tags[r_head], c_BANK};
    assign count        = r_count;
    assign lower_flag   = r_lower;
    assign upper_flag   = r_upper;
    assign overflow_err = r_overflow;
    assign bank_err     = r_bank_err;

    assign w_full         = (r_count == c_FULL);
    assign w_deq_fire     = deq_valid & deq_ready;
    assign w_enq_fire     = enq_valid & (~w_full | w_deq_fire);
    assign w_overflow_evt = enq_valid & w_full & ~w_deq_fire;
    // Mismatched tags are still stored so allocation order is preserved.
    assign w_bank_evt     = enq_valid & (enq_PR[1:0] != c_BANK);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq_fire, w_deq_fire})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Reset preloads tags INIT_FREE_BASE.. upward; entries past the tail are unused.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(LENGTH); i++) begin
                r_tags[i] <= LOG_LENGTH'(INIT_FREE_BASE + i);
            end
        end else if (w_enq_fire) begin
            r_tags[r_tail] <= enq_PR[LOG_LENGTH+1:2];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_head  <= '0;
            r_tail  <= c_RST_TAIL;
            r_count <= c_RST_COUNT;
        end else begin
            if (w_deq_fire) begin
                r_head <= r_head + 1'b1;
            end
            if (w_enq_fire) begin
                r_tail <= r_tail + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    // Flags compare the next count so they line up with count itself.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lower    <= 1'b0;
            r_upper    <= 1'b0;
            r_overflow <= 1'b0;
            r_bank_err <= 1'b0;
        end else begin
            r_lower <= (w_count_nxt < c_LOWER);
            r_upper <= (w_count_nxt > c_UPPER);
            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_bank_evt) begin
                r_bank_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_free_list_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_free_list_bank
// Description : Scoreboard bench for free_list_bank (BANK_ID=2), queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_free_list_bank;

    localparam logic [1:0] c_BANK = 2'd2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       enq_valid = 1'b0;
    logic [6:0] enq_PR = '0;
    logic       deq_valid;
    logic [6:0] deq_PR;
    logic       deq_ready = 1'b0;
    logic [5:0] count;
    logic       lower_flag;
    logic       upper_flag;
    logic       overflow_err;
    logic       bank_err;

    free_list_bank #(
        .BANK_ID(2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .enq_valid   (enq_valid),
        .enq_PR      (enq_PR),
        .deq_valid   (deq_valid),
        .deq_PR      (deq_PR),
        .deq_ready   (deq_ready),
        .count       (count),
        .lower_flag  (lower_flag),
        .upper_flag  (upper_flag),
        .overflow_err(overflow_err),
        .bank_err    (bank_err)
    );

    always #5 CLK = ~CLK;

    // Reference model: the free list is just an ordered queue of tags.
    logic [4:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_berr = 1'b0;
    logic       model_ok = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: mid-cycle, compare outputs to the model and pop on a dequeue.
    always @(negedge CLK) begin
        if (model_ok) begin
            logic       exp_valid;
            logic [6:0] exp_pr;
            exp_valid = !RST && (q.size() != 0);
            chk("count", 32'(count), 32'(q.size()));
            chk("deq_valid", 32'(deq_valid), 32'(exp_valid));
            chk("lower_flag", 32'(lower_flag), 32'(q.size() < 8));
            chk("upper_flag", 32'(upper_flag), 32'(q.size() > 24));
            chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
            chk("bank_err", 32'(bank_err), 32'(m_berr));
            if (exp_valid && deq_ready) begin
                exp_pr = {q.pop_front(), c_BANK};
                chk("deq_PR", 32'(deq_PR), 32'(exp_pr));
            end
        end
    end

    // Drive one cycle just after a rising edge, then commit the model after the next.
    task automatic step(input logic ev, input logic [4:0] tag, input logic [1:0] bb,
                        input logic dr, input logic rs);
        logic full, deq_f, enq_f;
        enq_valid = ev;
        enq_PR    = {tag, bb};
        deq_ready = dr;
        RST       = rs;
        full  = (q.size() == 32);
        deq_f = !rs && dr && (q.size() != 0);
        enq_f = !rs && ev && (!full || deq_f);
        @(posedge CLK);
        #1;
        if (rs) begin
            q.delete();
            for (int i = 8; i < 32; i++) q.push_back(5'(i));
            m_ovf    = 1'b0;
            m_berr   = 1'b0;
            model_ok = 1'b1;
        end else begin
            if (enq_f) q.push_back(tag);
            if (ev && full && !deq_f) m_ovf = 1'b1;
            if (ev && (bb != c_BANK)) m_berr = 1'b1;
        end
    endtask

    initial begin
        @(posedge CLK);
        #1;
        step(0, 0, c_BANK, 0, 1);
        step(0, 0, c_BANK, 0, 1);

        // Drain the reset contents, then poke the empty bank.
        for (int i = 0; i < 26; i++) step(0, 0, c_BANK, 1, 0);

        // Enqueue into empty with deq_ready: no bypass.
        step(1, 5'd1, c_BANK, 1, 0);
        step(0, 0, c_BANK, 0, 0);
        step(0, 0, c_BANK, 1, 0);

        // Fill to full, overflow alone, then enqueue with a concurrent dequeue.
        step(0, 0, c_BANK, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 5'(i), c_BANK, 0, 0);
        step(1, 5'd3, c_BANK, 0, 0);
        step(1, 5'd4, c_BANK, 1, 0);
        step(0, 0, c_BANK, 0, 0);

        // Random traffic with 50% duty on both sides.
        step(0, 0, c_BANK, 0, 1);
        for (int i = 0; i < 100; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), c_BANK,
                 1'($urandom_range(0, 1)), 0);
        end

        // Wrong bank bits: sticky error, tag still stored.
        step(1, 5'd9, 2'd1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, c_BANK, 1'($urandom_range(0, 1)), 0);

        // Bring occupancy to 13, then reset mid-stream.
        while (q.size() > 13) step(0, 0, c_BANK, 1, 0);
        while (q.size() < 13) step(1, 5'($urandom_range(0, 31)), c_BANK, 0, 0);
        step(1, 5'd7, c_BANK, 1, 1);
        step(0, 0, c_BANK, 0, 0);
        step(0, 0, c_BANK, 1, 0);
        step(0, 0, c_BANK, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/free_list_bank.md
# free_list_bank

One bank of the physical register free list. It stores the 5-bit in-bank tags of free physical registers: `PR = {tag, BANK_ID}` with 128 PRs over 4 banks.
- Writer side: the ROB commit path returns freed PRs.
- Reader side: rename dequeues new destination PRs.

Four instances, one per PRF bank, form the full free list. Occupancy flags feed rename's bank-balancing logic.

## Interface
- BANK_ID, default 0: bank index; low 2 bits of every PR this bank holds.
- LENGTH, default 32: entries per bank (PR_COUNT / bank count).
- LOG_LENGTH, default 5: tag and pointer width.
- INIT_FREE_BASE, default 8: first free tag after reset. Tags 0..7 of each bank back architectural regs 0..31.
- LOWER_THRESHOLD, default 8: low-occupancy flag threshold.
- UPPER_THRESHOLD, default 24: high-occupancy flag threshold.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- enq_valid  in  1  ROB returns a freed PR to this bank this cycle.
- enq_PR  in  7  freed PR; bits [1:0] must equal BANK_ID, bits [6:2] are stored as the tag.
- deq_valid  out  1  a free PR is available (count != 0).
- deq_PR  out  7  head PR, `{head tag, BANK_ID[1:0]}`.
- deq_ready  in  1  rename consumes the head this cycle; effective only when deq_valid=1.
- count  out  6  registered occupancy, 0..32.
- lower_flag  out  1  registered, count < LOWER_THRESHOLD.
- upper_flag  out  1  registered, count > UPPER_THRESHOLD.
- overflow_err  out  1  sticky; an enqueue arrived while full with no dequeue.
- bank_err  out  1  sticky; enq_PR[1:0] != BANK_ID on a valid enqueue.

## Operation
- Storage: circular array of LENGTH tags, head/tail pointers of LOG_LENGTH bits, count of LOG_LENGTH+1 bits. Pointers wrap 31 -> 0 by natural overflow.
- Dequeue fires when `deq_fire = deq_valid & deq_ready`. Then head += 1 and count -= 1.
- Enqueue fires when `enq_fire = enq_valid & (count != LENGTH | deq_fire)`:
  - array[tail] <= enq_PR[6:2];
  - tail += 1;
  - count += 1.
- Simultaneous enq_fire and deq_fire: count is unchanged and both pointers advance.
- Empty (count=0): deq_valid=0 and deq_ready is ignored. There is no enqueue-to-dequeue bypass: a PR enqueued into an empty bank is visible on deq_PR the next cycle.
- Full (count=32), enq_valid=1, deq_fire=0: the write is dropped, state is unchanged, and overflow_err is set. Correct allocation never reaches this state.
- Full with deq_fire: the enqueue is accepted and count stays 32.
- Mismatched bank bits: bank_err is set, and the tag is still enqueued, so the in-order contract holds.
- lower_flag and upper_flag are registered compares on the next-count value, so they track count in the same cycle.
- deq_PR and deq_valid are combinational from registered head and count. There is no combinational path from enq_* to deq_*.
- There is no state machine beyond the pointer FIFO; behaviour is fully determined by pointers and count.

## Timing
- Reset (RST high at a clock edge):
  - array[i] <= INIT_FREE_BASE + i for i = 0..(LENGTH-INIT_FREE_BASE-1); other entries are don't-care;
  - head=0, tail=24, count=24;
  - lower_flag=0, upper_flag=0, overflow_err=0, bank_err=0.
- While RST is high, deq_valid is forced to 0.
- First cycle after reset: deq_valid=1, deq_PR = 32 + BANK_ID.
- Reset mid-operation discards all contents and pointers and reinitialises as above. An enq or deq in the reset cycle is ignored.
- Dequeue latency: the head is available combinationally. The next head appears the cycle after deq_fire.
- Enqueue latency: 1 cycle to storage and to count/flags.
- Throughput: 1 enqueue and 1 dequeue per cycle, sustained.

## Test plan
- Reset, BANK_ID=2, deq_ready=1 for 24 cycles:
  - deq_PR sequence 34, 38, …, 126 (tags 8..31);
  - then deq_valid=0 and count=0;
  - lower_flag=1 from the cycle count drops to 7.
- From empty, enq PR 6 (tag 1) with deq_ready=1 in the same cycle: deq_valid=0 in that cycle; next cycle deq_valid=1, deq_PR=6, count=1.
- Reset, enqueue 8 returned PRs with no dequeue:
  - count reaches 32, upper_flag=1 from count 25;
  - a 9th enq alone sets overflow_err=1 and count stays 32;
  - a 10th enq with deq_ready=1 is accepted and count stays 32.
- Continuous enq and deq for 100 cycles with a random 50% duty on each: dequeued order equals enqueued order (after the initial 24), pointers wrap correctly past 31, and count is never outside 0..32.
- enq_PR[1:0] != BANK_ID: bank_err=1 and stays set until RST.
- Assert RST mid-stream with count=13: next cycle count=24, deq_PR=32+BANK_ID, and all error flags are clear.
